simon_iterative_core: RTL
=========================

# simon_iterative_core

Parametrised, iterative SIMON block cipher core covering every SIMON 2N/MN variant (N = 16…64, M = 2…4) with both encryption and decryption. It stores the full expanded key schedule in an internal T-entry round-key register file, so one expanded key serves any number of blocks in either direction. It keeps the newKey/ldKey/doneKey and newData/ldData/doneData/readData handshake of the existing fixed-width SIMON tops and replaces them as the single core instantiated per variant.

## Interface
- N, 64, word size in bits; block is 2N
- M, 3, key words (2, 3 or 4)
- T, 69, round count for the chosen (N, M) variant
- Co, 7, counter width; 2^Co > T
- ZSEQ, 3, index 0–4 of the standard z constant sequence (62 bits) for the variant
- clk  input  1  clock, all state updates on rising edge
- R  input  1  asynchronous, active-high reset
- newKey  input  1  request to load and expand `key`
- newData  input  1  request to process `plain`
- enc_dec  input  1  sampled with newData: 1 = encrypt, 0 = decrypt
- readData  input  1  host has consumed `cipher`; releases doneData
- plain  input  2N  input block {x, y}, x in upper half
- key  input  M×N  key words; key[0] = k0, the first round key
- ldKey  output  1  one-cycle pulse: key accepted
- ldData  output  1  one-cycle pulse: block accepted
- doneKey  output  1  level: key schedule complete and valid
- doneData  output  1  level: `cipher` valid
- cipher  output  2N  result block {x, y}, registered

## Operation
- FSM states: IDLE, KEYEXP, READY, RUN, DONE. Reset → IDLE. All outputs 0, counters 0, `cipher` 0.
- IDLE/READY + newKey: latch key[0..M-1] into RK[0..M-1]; pulse ldKey; clear doneKey; kcount = M; → KEYEXP.
- KEYEXP: one word per cycle into RK[kcount]. tmp = RK[kcount-1] >>> 3. If M = 4, tmp ^= RK[kcount-3]. tmp ^= tmp >>> 1. RK[kcount] = ~RK[kcount-M] ^ tmp ^ z[(kcount-M) mod 62] ^ 3. After RK[T-1] is written, set doneKey and go → READY.
- READY + newData (newKey low): latch plain, enc_dec; pulse ldData; rcount = 0; → RUN.
- newKey and newData together in READY: newKey wins and newData is dropped.
- RUN, one round per cycle with f(v) = ((v<<<1) & (v<<<8)) ^ (v<<<2):
  - Encrypt uses k = RK[rcount]: x′ = y ^ f(x) ^ k, y′ = x.
  - Decrypt uses k = RK[T-1-rcount]: x′ = y, y′ = x ^ f(y) ^ k.
  - After round T-1: register the result into `cipher`, set doneData, go → DONE.
- DONE: `cipher` and doneData are held. readData → clear doneData, go → READY; `cipher` keeps its value.
- Ignored inputs:
  - newData in IDLE, KEYEXP, RUN or DONE.
  - newKey in KEYEXP, RUN or DONE.
  - readData outside DONE.
- Rotations and XORs are mod 2^N, and the index wraps only through z (mod 62).
- Reset asserted in any state: immediate return to IDLE with outputs cleared. RK contents become don't-care, and doneKey stays 0 until a new schedule completes.

## Timing
- Edge E0 samples newKey. ldKey is high for the cycle after E0. Edges E1…E(T-M) write RK[M…T-1]. doneKey rises after E(T-M): SIMON32/64 = 28 cycles after ldKey, SIMON128/192 = 66.
- Edge D0 samples newData. ldData is high for the cycle after D0. Edges D1…DT perform rounds 0…T-1. doneData and `cipher` update together after DT, T cycles after ldData rises.
- Earliest next newData acceptance: the edge after the edge that samples readData.
- Back-to-back blocks: T + 2 cycles per block minimum.
- The handshake inputs are level-sampled. The host drops newKey/newData after seeing ldKey/ldData; a request still high on a later edge counts as a new request.

## Test plan
- SIMON32/64 (N=16, M=4, T=32, ZSEQ=0). Encrypt key {k3..k0} = 1918,1110,0908,0100 with plain 6565_6877 → cipher c69b_e9bb, doneData exactly 32 cycles after ldData.
- Same key, decrypt cipher c69b_e9bb → plain 6565_6877. Then encrypt again without reloading the key, giving identical cipher.
- SIMON64/128 (N=32, M=4, T=44, ZSEQ=3). Key 1b1a1918,13121110,0b0a0908,03020100 with plain 656b696c_20646e75 → 44c8fc20_b9dfa07a. doneKey rises 40 cycles after ldKey.
- Protocol checks:
  - Assert newData during KEYEXP: no ldData is produced.
  - Assert newKey and newData together in READY: only ldKey pulses.
  - Assert newData while in DONE: it is ignored until readData.
- Assert R mid-RUN at round 10: all outputs 0 immediately and doneKey stays 0. After reloading the key and running a block, the cipher is correct.
- Randomised default parameters (SIMON128/192): 200 blocks compared against a reference model. For each block, checks that enc→dec round-trip returns the plaintext.

Source files
------------

// File: rtl/simon_iterative_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : simon_iterative_core_if
//  Description : Host <-> core bundle for the iterative SIMON core. Carries
//                the key and data request/acknowledge handshakes, the
//                direction select, the input block and key, and the result.
//  Ports       : newKey, newData, enc_dec, readData, plain, key   (host -> core)
//                ldKey, ldData, doneKey, doneData, cipher         (core -> host)
//  Modports    : master = host side, slave = core side
//  Revision    : 1.0  initial release
// ============================================================================
interface simon_iterative_core_if #(
    parameter int N = 64,
    parameter int M = 3
);
    logic             newKey;
    logic             newData;
    logic             enc_dec;
    logic             readData;
    logic [2*N-1:0]   plain;
    logic [M*N-1:0]   key;
    logic             ldKey;
    logic             ldData;
    logic             doneKey;
    logic             doneData;
    logic [2*N-1:0]   cipher;

    modport master (
        output newKey, newData, enc_dec, readData, plain, key,
        input  ldKey, ldData, doneKey, doneData, cipher
    );

    modport slave (
        input  newKey, newData, enc_dec, readData, plain, key,
        output ldKey, ldData, doneKey, doneData, cipher
    );
endinterface
`default_nettype wire

// File: rtl/simon_iterative_core.sv
`default_nettype none
// ============================================================================
//  Module      : simon_iterative_core
//  Description : Iterative SIMON 2N/MN block cipher, one round per clock,
//                encrypt and decrypt. The full expanded key schedule is kept
//                in a T-entry round-key register file, so one key expansion
//                serves any number of blocks in either direction.
//  Ports       : clk  - clock, rising edge
//                R    - asynchronous active-high reset
//                bus  - simon_iterative_core_if.slave (handshakes, plain,
//                       key, enc_dec in; ldKey/ldData pulses, doneKey/
//                       doneData levels, registered cipher out)
//  Revision    : 1.0  initial release
// ============================================================================
module simon_iterative_core #(
    parameter int N    = 64,
    parameter int M    = 3,
    parameter int T    = 69,
    parameter int Co   = 7,
    parameter int ZSEQ = 3
) (
    input  wire logic              clk,
    input  wire logic              R,
    simon_iterative_core_if.slave  bus
);
    // Round-key file index width; counters are Co bits and only the low AW
    // bits address the file.
    localparam int AW = $clog2(T);

    // The five standard z sequences, leftmost character = z[0].
    localparam logic [61:0] ZBITS =
        (ZSEQ == 0) ? 62'b11111010001001010110000111001101111101000100101011000011100110 :
        (ZSEQ == 1) ? 62'b10001110111110010011000010110101000111011111001001100001011010 :
        (ZSEQ == 2) ? 62'b10101111011100000011010010011000101000010001111110010110110011 :
        (ZSEQ == 3) ? 62'b11011011101011000110010111100000010010001010011100110100001111 :
                      62'b11010001111001101011011000100000010111000011001010010011101111;

    localparam logic [N-1:0] THREE = N'(3);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        READY  = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
        return {v[N-2:0], v[N-1]};
    endfunction
    function automatic logic [N-1:0] rotl2(input logic [N-1:0] v);
        return {v[N-3:0], v[N-1:N-2]};
    endfunction
    function automatic logic [N-1:0] rotl8(input logic [N-1:0] v);
        return {v[N-9:0], v[N-1:N-8]};
    endfunction
    function automatic logic [N-1:0] rotr1(input logic [N-1:0] v);
        return {v[0], v[N-1:1]};
    endfunction
    function automatic logic [N-1:0] rotr3(input logic [N-1:0] v);
        return {v[2:0], v[N-1:3]};
    endfunction
    function automatic logic [N-1:0] simon_f(input logic [N-1:0] v);
        return (rotl1(v) & rotl8(v)) ^ rotl2(v);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q,     state_d;
    logic [Co-1:0]   kcount_q,    kcount_d;
    logic [5:0]      zcnt_q,      zcnt_d;
    logic [Co-1:0]   rcount_q,    rcount_d;
    logic [N-1:0]    x_q,         x_d;
    logic [N-1:0]    y_q,         y_d;
    logic            enc_q,       enc_d;
    logic [2*N-1:0]  cipher_q,    cipher_d;
    logic            ld_key_q,    ld_key_d;
    logic            ld_data_q,   ld_data_d;
    logic            done_key_q,  done_key_d;
    logic            done_data_q, done_data_d;

    logic [N-1:0]    rk_q [T];

    // ------------------------------------------------------------------
    // Key schedule datapath
    // ------------------------------------------------------------------
    logic            w_key_load;
    logic            w_kexp_we;
    logic [AW-1:0]   w_kidx;
    logic [N-1:0]    w_km1;
    logic [N-1:0]    w_km3;
    logic [N-1:0]    w_kmm;
    logic [N-1:0]    w_ktmp;
    logic [N-1:0]    w_kword;
    logic            w_zbit;

    assign w_kidx = kcount_q[AW-1:0];
    assign w_km1  = rk_q[w_kidx - AW'(1)];
    assign w_kmm  = rk_q[w_kidx - AW'(M)];
    assign w_zbit = ZBITS[6'd61 - zcnt_q];

    // Only the four-word key mixes in the word three positions back.
    generate
        if (M == 4) begin : g_m4_tap
            assign w_km3 = rk_q[w_kidx - AW'(3)];
        end else begin : g_no_tap
            assign w_km3 = '0;
        end
    endgenerate

    always_comb begin
        w_ktmp  = rotr3(w_km1) ^ w_km3;
        w_ktmp  = w_ktmp ^ rotr1(w_ktmp);
        w_kword = ~w_kmm ^ w_ktmp ^ {{(N-1){1'b0}}, w_zbit} ^ THREE;
    end

    // Register file has no reset: its contents are only trusted once
    // doneKey is set, which reset clears.
    always_ff @(posedge clk) begin
        if (w_key_load) begin
            for (int i = 0; i < M; i++) begin
                rk_q[i] <= bus.key[i*N +: N];
            end
        end else if (w_kexp_we) begin
            rk_q[w_kidx] <= w_kword;
        end
    end

    // ------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------
    logic [AW-1:0]   w_ridx;
    logic [N-1:0]    w_rk;
    logic [N-1:0]    w_rx;
    logic [N-1:0]    w_ry;

    // Decryption walks the schedule backwards.
    assign w_ridx = enc_q ? rcount_q[AW-1:0] : (AW'(T - 1) - rcount_q[AW-1:0]);
    assign w_rk   = rk_q[w_ridx];

    always_comb begin
        if (enc_q) begin
            w_rx = y_q ^ simon_f(x_q) ^ w_rk;
            w_ry = x_q;
        end else begin
            w_rx = y_q;
            w_ry = x_q ^ simon_f(y_q) ^ w_rk;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        kcount_d    = kcount_q;
        zcnt_d      = zcnt_q;
        rcount_d    = rcount_q;
        x_d         = x_q;
        y_d         = y_q;
        enc_d       = enc_q;
        cipher_d    = cipher_q;
        ld_key_d    = 1'b0;
        ld_data_d   = 1'b0;
        done_key_d  = done_key_q;
        done_data_d = done_data_q;
        w_key_load  = 1'b0;
        w_kexp_we   = 1'b0;

        case (state_q)
            IDLE, READY: begin
                // A key request always beats a simultaneous data request.
                if (bus.newKey) begin
                    w_key_load = 1'b1;
                    ld_key_d   = 1'b1;
                    done_key_d = 1'b0;
                    kcount_d   = Co'(M);
                    zcnt_d     = 6'd0;
                    state_d    = KEYEXP;
                end else if ((state_q == READY) && bus.newData) begin
                    x_d       = bus.plain[2*N-1:N];
                    y_d       = bus.plain[N-1:0];
                    enc_d     = bus.enc_dec;
                    rcount_d  = '0;
                    ld_data_d = 1'b1;
                    state_d   = RUN;
                end
            end
            KEYEXP: begin
                w_kexp_we = 1'b1;
                kcount_d  = kcount_q + Co'(1);
                zcnt_d    = (zcnt_q == 6'd61) ? 6'd0 : zcnt_q + 6'd1;
                if (kcount_q == Co'(T - 1)) begin
                    done_key_d = 1'b1;
                    state_d    = READY;
                end
            end
            RUN: begin
                x_d      = w_rx;
                y_d      = w_ry;
                rcount_d = rcount_q + Co'(1);
                if (rcount_q == Co'(T - 1)) begin
                    cipher_d    = {w_rx, w_ry};
                    done_data_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.readData) begin
                    done_data_d = 1'b0;
                    state_d     = READY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q     <= IDLE;
            kcount_q    <= '0;
            zcnt_q      <= '0;
            rcount_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            enc_q       <= 1'b0;
            cipher_q    <= '0;
            ld_key_q    <= 1'b0;
            ld_data_q   <= 1'b0;
            done_key_q  <= 1'b0;
            done_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kcount_q    <= kcount_d;
            zcnt_q      <= zcnt_d;
            rcount_q    <= rcount_d;
            x_q         <= x_d;
            y_q         <= y_d;
            enc_q       <= enc_d;
            cipher_q    <= cipher_d;
            ld_key_q    <= ld_key_d;
            ld_data_q   <= ld_data_d;
            done_key_q  <= done_key_d;
            done_data_q <= done_data_d;
        end
    end

    assign bus.ldKey    = ld_key_q;
    assign bus.ldData   = ld_data_q;
    assign bus.doneKey  = done_key_q;
    assign bus.doneData = done_data_q;
    assign bus.cipher   = cipher_q;

endmodule
`default_nettype wire
